// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   RV32 fetch stage. Owns the PC, runs a req/ack handshake with a
//   variable-latency instruction memory, and presents one instruction at a
//   time to decode through a valid/stall handshake. Execute may redirect the
//   PC. Misaligned redirect targets and memory timeouts land in a sticky
//   error state that only rst clears.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   imem_req/imem_addr   registered request and the PC register
//   imem_ack/imem_rdata  memory response, sampled on the rising edge
//   stall                decode not ready; the current instruction is held
//   redirect/redirect_pc taken branch/jal/jalr and its target
//   instr/instr_pc       fetched instruction and its address
//   pc_plus4             instr_pc + 4 (combinational)
//   instr_valid          instr/instr_pc are valid
//   fetch_err            sticky error flag
//
// state | meaning
// IDLE  | out of reset; request goes out on the next edge
// REQ   | request outstanding on imem_addr
// FLUSH | request outstanding but its data is stale (redirect arrived)
// HOLD  | instruction presented to decode, waiting for it to be consumed
// ERR   | misaligned redirect or memory timeout; exit only by rst
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FLUSH,
    S_HOLD,
    S_ERR
  } state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;

  logic        misaligned;
  logic [9:0]  cnt_inc;
  logic        timeout_hit;

  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign cnt_inc     = cnt_q + 10'd1;
  // This ack-less edge is the TIMEOUT-th consecutive one.
  assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        cnt_d   = 10'd0;
      end

      S_REQ: begin
        if (redirect && misaligned) begin
          state_d = S_ERR;
        end else if (redirect && imem_ack) begin
          // Response belongs to the wrong path; re-issue at the target.
          pc_d  = redirect_pc;
          cnt_d = 10'd0;
        end else if (redirect) begin
          // Request already issued cannot be withdrawn: wait it out in FLUSH.
          if (timeout_hit) begin
            state_d = S_ERR;
          end else begin
            pend_d  = redirect_pc;
            state_d = S_FLUSH;
            cnt_d   = cnt_inc;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = S_HOLD;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_FLUSH: begin
        if (redirect && misaligned) begin
          state_d = S_ERR;
        end else if (imem_ack) begin
          // A redirect arriving with the ack is newer than the pending target.
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = S_REQ;
          cnt_d   = 10'd0;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
          if (redirect) pend_d = redirect_pc;
        end
      end

      S_HOLD: begin
        if (redirect && misaligned) begin
          state_d = S_ERR;
        end else if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = S_REQ;
          req_d   = 1'b1;
          cnt_d   = 10'd0;
        end else if (!stall) begin
          valid_d = 1'b0;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
          req_d   = 1'b1;
          cnt_d   = 10'd0;
        end
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    if (state_d == S_ERR) begin
      req_d   = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 10'd0;
      pend_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + 32'd4;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (TIMEOUT=4). Expected instructions are pushed
// to a queue when the bench acks a live request; a monitor pops one each
// time instr_valid rises and compares instr, instr_pc and pc_plus4.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic        prev_valid = 1'b0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ack_push(input logic [31:0] data, input logic [31:0] pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back({data, pc});
  endtask

  // Scoreboard monitor: a rising instr_valid marks a newly presented instruction.
  always @(negedge clk) begin
    logic [63:0] e;
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr", instr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e[63:32]);
        chk("sb_instr_pc", instr_pc, e[31:0]);
        chk("sb_pc_plus4", pc_plus4, e[31:0] + 32'd4);
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    cyc();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b0;

    // First fetch, zero-wait memory.
    cyc();
    chk("e1_req", {31'd0, imem_req}, 32'd1);
    chk("e1_addr", imem_addr, 32'd0);
    ack_push(32'h0010_8093, 32'd0);
    cyc();
    imem_ack = 1'b0;
    chk("e2_req", {31'd0, imem_req}, 32'd0);
    chk("e2_valid", {31'd0, instr_valid}, 32'd1);

    // Stall for 3 cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h0010_8093);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    cyc();
    chk("cons_valid", {31'd0, instr_valid}, 32'd0);
    chk("cons_req", {31'd0, imem_req}, 32'd1);
    chk("cons_addr", imem_addr, 32'd4);

    // Fetch at 4, consume, request goes to 8.
    ack_push(32'h1111_1111, 32'd4);
    cyc();
    imem_ack = 1'b0;
    cyc();
    chk("a8_addr", imem_addr, 32'h8);
    chk("a8_req", {31'd0, imem_req}, 32'd1);

    // Redirect to 0x80 while the request to 0x8 is outstanding.
    redirect = 1'b1;
    redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    chk("fl_addr0", imem_addr, 32'h8);
    chk("fl_req0", {31'd0, imem_req}, 32'd1);
    cyc();
    chk("fl_addr1", imem_addr, 32'h8);
    chk("fl_valid1", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_ack = 1'b0;
    chk("fl_valid2", {31'd0, instr_valid}, 32'd0);
    chk("fl_req2", {31'd0, imem_req}, 32'd1);
    chk("fl_addr2", imem_addr, 32'h80);
    cyc();
    chk("fl_valid3", {31'd0, instr_valid}, 32'd0);
    ack_push(32'h3333_3333, 32'h80);
    cyc();
    imem_ack = 1'b0;
    chk("h80_valid", {31'd0, instr_valid}, 32'd1);

    // Redirect in HOLD with stall high.
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    stall = 1'b0;
    chk("hr_valid", {31'd0, instr_valid}, 32'd0);
    chk("hr_req", {31'd0, imem_req}, 32'd1);
    chk("hr_addr", imem_addr, 32'h40);
    ack_push(32'h4444_4444, 32'h40);
    cyc();
    imem_ack = 1'b0;
    cyc();
    chk("a44_addr", imem_addr, 32'h44);

    // Misaligned redirect -> sticky error.
    redirect = 1'b1;
    redirect_pc = 32'h42;
    cyc();
    redirect = 1'b0;
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = i[0];
      redirect = 1'b1;
      redirect_pc = 32'h100;
      cyc();
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    redirect = 1'b0;
    rst = 1'b1;
    #1;
    chk("err_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("err_rst_addr", imem_addr, 32'd0);
    cyc();
    rst = 1'b0;

    // Timeout: four ack-less edges in REQ.
    cyc();
    chk("to_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("to_noerr", {31'd0, fetch_err}, 32'd0);
      chk("to_req_hi", {31'd0, imem_req}, 32'd1);
    end
    cyc();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_err_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("to_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("to_rst_addr", imem_addr, 32'd0);
    cyc();
    rst = 1'b0;

    // Ack on the 4th edge is still accepted.
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    ack_push(32'h5555_5555, 32'd0);
    cyc();
    imem_ack = 1'b0;
    chk("to4_err", {31'd0, fetch_err}, 32'd0);
    chk("to4_valid", {31'd0, instr_valid}, 32'd1);
    cyc();
    cyc();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
